csr_trap_seq: RTL and testbench

Sequencer that owns the single write port of the machine-mode CSR file. It arbitrates between pipeline CSR instructions, trap entry and mret. Trap entry and mret each need several CSR updates; the block performs them one write per cycle and then issues a PC redirect to the fetch stage. It sits between the execute/commit stage and the CSR file.

---
 rtl/csr_trap_seq_if.sv | 42 ++++
 rtl/csr_trap_seq.sv | 162 ++++++++++++++++
 tb/tb_csr_trap_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_seq_if.sv
// Bundle of the request, CSR-file and redirect signals around csr_trap_seq.
// slave = the sequencer, master = the pipeline/CSR-file side that drives it.
interface csr_trap_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            insn_req;
  logic [11:0]     insn_addr;
  logic [1:0]      insn_funct;
  logic [XLEN-1:0] insn_wdata;
  logic            insn_ack;
  logic            trap_req;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_tval;
  logic            mret_req;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_funct;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wen;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport slave (
    input  insn_req, insn_addr, insn_funct, insn_wdata,
    input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    input  mstatus_i, mtvec_i, mepc_i,
    output insn_ack, csr_addr, csr_funct, csr_wdata, csr_wen,
    output redirect_valid, redirect_pc, busy
  );

  modport master (
    output insn_req, insn_addr, insn_funct, insn_wdata,
    output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    output mstatus_i, mtvec_i, mepc_i,
    input  insn_ack, csr_addr, csr_funct, csr_wdata, csr_wen,
    input  redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/csr_trap_seq.sv
// Owns the M-mode CSR write port: passes CSR instructions through, sequences trap entry and mret.
// Optional: define VECTORED_TRAP_EN to honour mtvec vectored mode for interrupts.
module csr_trap_seq #(
  parameter int unsigned XLEN = 64
) (
  input logic           clk,
  input logic           rst,
  csr_trap_seq_if.slave bus
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;
  localparam logic [1:0]  FunctRw     = 2'b01;

  typedef enum logic [2:0] {
    StIdle, StTEpc, StTCause, StTTval, StTStatus, StTJump, StMStatus, StMJump
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, cause_q, tval_q;

  logic [11:0]     csr_addr;
  logic [1:0]      csr_funct;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wen;
  logic            insn_ack;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] trap_target;

  assign tvec_base = {bus.mtvec_i[XLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
  // Interrupts in vectored mode jump to base + 4*code; the interrupt flag itself is dropped.
  assign trap_target = (bus.mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1]) ?
                       tvec_base + {cause_q[XLEN-3:0], 2'b00} : tvec_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.mtvec_i[1:0];
  assign trap_target       = tvec_base;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else if (state_q == StIdle && bus.trap_req) begin
      pc_q    <= bus.trap_pc;
      cause_q <= bus.trap_cause;
      tval_q  <= bus.trap_tval;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.trap_req) begin
          state_d = StTEpc;
        end else if (bus.mret_req) begin
          state_d = StMStatus;
        end
      end
      StTEpc:    state_d = StTCause;
      StTCause:  state_d = StTTval;
      StTTval:   state_d = StTStatus;
      StTStatus: state_d = StTJump;
      StTJump:   state_d = StIdle;
      StMStatus: state_d = StMJump;
      StMJump:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    csr_addr       = '0;
    csr_funct      = '0;
    csr_wdata      = '0;
    csr_wen        = 1'b0;
    insn_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StIdle: begin
        // Instructions yield to trap/mret and are never acknowledged while in reset.
        if (!rst && !bus.trap_req && !bus.mret_req && bus.insn_req) begin
          csr_addr  = bus.insn_addr;
          csr_funct = bus.insn_funct;
          csr_wdata = bus.insn_wdata;
          csr_wen   = 1'b1;
          insn_ack  = 1'b1;
        end
      end
      StTEpc: begin
        csr_addr  = AddrMepc;
        csr_funct = FunctRw;
        csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        csr_wen   = 1'b1;
      end
      StTCause: begin
        csr_addr  = AddrMcause;
        csr_funct = FunctRw;
        csr_wdata = cause_q;
        csr_wen   = 1'b1;
      end
      StTTval: begin
        csr_addr  = AddrMtval;
        csr_funct = FunctRw;
        csr_wdata = tval_q;
        csr_wen   = 1'b1;
      end
      StTStatus: begin
        csr_addr         = AddrMstatus;
        csr_funct        = FunctRw;
        csr_wdata        = bus.mstatus_i;
        csr_wdata[7]     = bus.mstatus_i[3];
        csr_wdata[3]     = 1'b0;
        csr_wdata[12:11] = 2'b11;
        csr_wen          = 1'b1;
      end
      StTJump: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
      end
      StMStatus: begin
        csr_addr     = AddrMstatus;
        csr_funct    = FunctRw;
        csr_wdata    = bus.mstatus_i;
        csr_wdata[3] = bus.mstatus_i[7];
        csr_wdata[7] = 1'b1;
        csr_wen      = 1'b1;
      end
      StMJump: begin
        redirect_valid = 1'b1;
        redirect_pc    = bus.mepc_i;
      end
      default: ;
    endcase
  end

  assign bus.csr_addr       = csr_addr;
  assign bus.csr_funct      = csr_funct;
  assign bus.csr_wdata      = csr_wdata;
  assign bus.csr_wen        = csr_wen;
  assign bus.insn_ack       = insn_ack;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_csr_trap_seq.sv
// Randomized scoreboard bench for csr_trap_seq: a per-cycle request model predicts every
// CSR write / redirect with its cycle stamp, and a monitor pops and compares them.
module tb_csr_trap_seq;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #5 clk = ~clk;

  csr_trap_seq_if #(.XLEN(XLEN)) bus ();

  csr_trap_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          stamp;
    bit          redir;
    logic [11:0] addr;
    logic [1:0]  funct;
    logic [63:0] data;
    bit          ack;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  bit   exp_busy = 1'b0;

  function automatic void chk(input string name, input logic [127:0] got,
                              input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endfunction

  function automatic void push(input int st, input bit rd, input logic [11:0] a,
                               input logic [1:0] f, input logic [63:0] d, input bit ak);
    exp_t e;
    e.stamp = st; e.redir = rd; e.addr = a; e.funct = f; e.data = d; e.ack = ak;
    q.push_back(e);
  endfunction

  // Architectural results written as plain bit arithmetic on the CSR values.
  function automatic logic [63:0] trap_status(input logic [63:0] ms);
    logic [63:0] mie;
    mie = {63'b0, ms[3]};
    return (ms & ~64'h1888) | (mie << 7) | 64'h1800;
  endfunction

  function automatic logic [63:0] mret_status(input logic [63:0] ms);
    logic [63:0] mpie;
    mpie = {63'b0, ms[7]};
    return (ms & ~64'h88) | (mpie << 3) | 64'h80;
  endfunction

  function automatic logic [63:0] trap_target(input logic [63:0] tvec, input logic [63:0] cause);
    logic [63:0] t;
    t = tvec & ~64'h3;
`ifdef VECTORED_TRAP_EN
    if ((tvec & 64'h3) == 64'h1 && cause[63]) t = t + ((cause & ~(64'h1 << 63)) << 2);
`endif
    return t;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: decides once per cycle what the sequencer accepts.
  initial forever begin
    @(negedge clk);
    exp_busy = (busy_cnt != 0);
    if (rst) begin
      exp_t keep[$];
      busy_cnt = 0;
      exp_busy = 1'b0;
      for (int i = 0; i < q.size(); i++) if (q[i].stamp < cyc) keep.push_back(q[i]);
      q = keep;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
    end else if (bus.trap_req) begin
      push(cyc + 1, 1'b0, 12'h341, 2'b01, bus.trap_pc & ~64'h3, 1'b0);
      push(cyc + 2, 1'b0, 12'h342, 2'b01, bus.trap_cause, 1'b0);
      push(cyc + 3, 1'b0, 12'h343, 2'b01, bus.trap_tval, 1'b0);
      push(cyc + 4, 1'b0, 12'h300, 2'b01, trap_status(bus.mstatus_i), 1'b0);
      push(cyc + 5, 1'b1, 12'h0, 2'b00, trap_target(bus.mtvec_i, bus.trap_cause), 1'b0);
      busy_cnt = 5;
    end else if (bus.mret_req) begin
      push(cyc + 1, 1'b0, 12'h300, 2'b01, mret_status(bus.mstatus_i), 1'b0);
      push(cyc + 2, 1'b1, 12'h0, 2'b00, bus.mepc_i, 1'b0);
      busy_cnt = 2;
    end else if (bus.insn_req) begin
      push(cyc, 1'b0, bus.insn_addr, bus.insn_funct, bus.insn_wdata, 1'b1);
    end
  end

  // Monitor: compares every DUT output event against the head of the queue.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      chk("busy", 128'(bus.busy), 128'(exp_busy));
      if (bus.csr_wen || bus.redirect_valid || bus.insn_ack) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output cyc=%0d got wen=%b rv=%b ack=%b exp none", cyc,
                   bus.csr_wen, bus.redirect_valid, bus.insn_ack);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_kind", 128'({cyc, bus.csr_wen, bus.redirect_valid, bus.insn_ack}),
              128'({e.stamp, !e.redir, e.redir, e.ack}));
          if (e.redir) chk("redirect_pc", 128'(bus.redirect_pc), 128'(e.data));
          else chk("csr_write", 128'({bus.csr_addr, bus.csr_funct, bus.csr_wdata}),
                   128'({e.addr, e.funct, e.data}));
        end
      end else if (q.size() != 0 && q[0].stamp < cyc) begin
        exp_t e;
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_event cyc=%0d got none exp stamp=%0d addr=%h data=%h", cyc,
                 e.stamp, e.addr, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input bit want_redirect, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = want_redirect ? bus.redirect_valid : bus.insn_ack;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s got no handshake exp one within 40 cycles", name);
    end
    tick();
  endtask

  task automatic do_insn(input logic [11:0] a, input logic [1:0] f, input logic [63:0] d);
    bus.insn_addr = a; bus.insn_funct = f; bus.insn_wdata = d; bus.insn_req = 1'b1;
    wait_out(1'b0, "insn_ack");
    bus.insn_req = 1'b0;
  endtask

  task automatic do_trap(input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval,
                         input logic [63:0] ms, input logic [63:0] tvec);
    bus.trap_pc = pc; bus.trap_cause = cause; bus.trap_tval = tval;
    bus.mstatus_i = ms; bus.mtvec_i = tvec; bus.trap_req = 1'b1;
    wait_out(1'b1, "trap_redirect");
    bus.trap_req = 1'b0;
  endtask

  task automatic do_mret(input logic [63:0] ms, input logic [63:0] epc);
    bus.mstatus_i = ms; bus.mepc_i = epc; bus.mret_req = 1'b1;
    wait_out(1'b1, "mret_redirect");
    bus.mret_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.insn_req = 1'b0; bus.insn_addr = '0; bus.insn_funct = '0; bus.insn_wdata = '0;
    bus.trap_req = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0; bus.trap_tval = '0;
    bus.mret_req = 1'b0; bus.mstatus_i = '0; bus.mtvec_i = '0; bus.mepc_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("reset_ctrl", 128'({bus.csr_wen, bus.insn_ack, bus.redirect_valid, bus.busy,
                            bus.csr_addr, bus.csr_funct}), 128'(0));
    chk("reset_data", {bus.csr_wdata, bus.redirect_pc}, 128'(0));
    tick();

    do_insn(12'h340, 2'b01, 64'h55);
    do_trap(64'h8000_0102, 64'h2, 64'hDEAD, 64'h8, 64'h8000_0001);

    // All three requests at once: trap first, then mret, then the stalled instruction.
    bus.trap_pc = 64'h1000; bus.trap_cause = 64'hB; bus.trap_tval = 64'h0;
    bus.mstatus_i = 64'h8; bus.mtvec_i = 64'h4000; bus.mepc_i = 64'h2222;
    bus.insn_addr = 12'h340; bus.insn_funct = 2'b10; bus.insn_wdata = 64'hF0;
    bus.trap_req = 1'b1; bus.mret_req = 1'b1; bus.insn_req = 1'b1;
    wait_out(1'b1, "combo_trap");
    bus.trap_req = 1'b0;
    wait_out(1'b1, "combo_mret");
    bus.mret_req = 1'b0;
    wait_out(1'b0, "combo_insn");
    bus.insn_req = 1'b0;

    do_mret(64'h1880, 64'h8000_0200);

    // Reset while T_CAUSE is on the bus: the rest of the sequence must vanish.
    bus.trap_pc = 64'h3000; bus.trap_cause = 64'h5; bus.trap_tval = 64'h77;
    bus.trap_req = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    bus.trap_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("reset_abort", 128'({bus.csr_wen, bus.redirect_valid, bus.busy}), 128'(0));
    tick();
    do_trap(64'h3004, 64'h5, 64'h78, 64'h0, 64'h100);

    do_trap(64'h10, 64'h8000_0000_0000_0007, 64'h0, 64'h88, 64'h8000_0001);

    for (int i = 0; i < 60; i++) begin
      int unsigned op;
      logic [63:0] cause;
      op = $urandom_range(0, 2);
      bus.mstatus_i = {$urandom, $urandom};
      bus.mtvec_i   = {$urandom, $urandom};
      if (op == 0) begin
        do_insn(12'($urandom), 2'($urandom_range(1, 3)), {$urandom, $urandom});
      end else if (op == 1) begin
        cause = {32'b0, 32'($urandom_range(0, 31))};
        if ($urandom_range(0, 1) == 1) cause = cause | (64'h1 << 63);
        do_trap({$urandom, $urandom}, cause, {$urandom, $urandom}, bus.mstatus_i, bus.mtvec_i);
      end else begin
        do_mret(bus.mstatus_i, {$urandom, $urandom});
      end
    end

    repeat (5) tick();
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
